transfer_authorizer: RTL and testbench
======================================

Name: transfer_authorizer

Overview:
- Downstream consumer of the key-verification stage.
- Per transfer request: waits for the verifier's result, checks funds against the supplied balance, and issues a one-cycle grant or deny with a reason code.
- Counts consecutive failed verifications and locks the account out for a fixed period after too many.
- Sits between the verification datapath and the ledger/balance update logic.

Parameters:
- AMT_W, 8: width of amount, balance and new_balance.
- MAX_FAILS, 3: consecutive key failures (including timeouts) that trigger lockout; range 1..7.
- TIMEOUT, 16: cycles allowed in WAIT_VERIFY for verify_done; minimum 2.
- LOCK_CYCLES, 64: lockout duration in cycles; minimum 1.

Ports:
- clock, input, 1: rising-edge clock.
- resetn, input, 1: asynchronous active-low reset.
- req, input, 1: start-transfer request; sampled only in IDLE.
- amount, input, AMT_W: transfer amount; latched when req is accepted.
- balance, input, AMT_W: current balance; latched when req is accepted.
- verify_done, input, 1: verifier result valid strobe.
- correct, input, 1: verifier result; meaningful only when verify_done=1.
- busy, output, 1: high in every state except IDLE.
- grant, output, 1: one-cycle pulse; transfer approved.
- deny, output, 1: one-cycle pulse; transfer rejected.
- deny_code, output, 2: 00 none, 01 bad key, 10 timeout, 11 insufficient funds. Valid while deny=1, otherwise 00.
- new_balance, output, AMT_W: balance minus amount; updated on grant, held otherwise.
- locked, output, 1: high while in LOCKED.
- fail_count, output, 3: current consecutive-failure count.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE.
  - busy, grant, deny, locked = 0; deny_code = 00; new_balance = 0; fail_count = 0.
  - All internal timers and latches are cleared.
- All outputs are registered; states are Moore-decoded.
- IDLE:
  - If req=1, latch amount and balance, clear the timer, and go to WAIT_VERIFY.
  - Otherwise stay in IDLE.
- WAIT_VERIFY:
  - The timer increments each cycle.
  - verify_done=1 and correct=1 → CHECK_FUNDS.
  - verify_done=1 and correct=0 → fail_count+1; go to DENY with code 01.
  - Timer reaches TIMEOUT-1 with verify_done=0 → fail_count+1; go to DENY with code 10.
  - If verify_done arrives on the final timeout cycle, verify_done wins over the timeout.
  - verify_done outside WAIT_VERIFY is ignored.
- CHECK_FUNDS:
  - amount ≤ balance (unsigned) → GRANT; new_balance = balance − amount, with no wrap possible.
  - amount > balance → DENY with code 11. fail_count is unchanged: a funds failure is not a key failure.
  - amount = 0 → GRANT with new_balance = balance.
- GRANT:
  - grant=1 for exactly one cycle; fail_count cleared to 0; next state IDLE.
  - Latency: grant rises on the second rising edge after the edge that sampled verify_done=1.
- DENY:
  - deny=1 and deny_code set for exactly one cycle.
  - If fail_count ≥ MAX_FAILS, go to LOCKED; otherwise go to IDLE.
- LOCKED:
  - locked=1; req is ignored (no grant, no deny).
  - The lock timer counts LOCK_CYCLES cycles, then the block clears fail_count and locked and returns to IDLE.
- fail_count saturates at 7.
- req held high is accepted again in the first IDLE cycle after a transfer completes. Back-to-back transfers are therefore spaced by at least one IDLE cycle.
- amount and balance changing after acceptance have no effect on the in-flight transfer.

Optional Feature:
- Macro: AUTH_AUDIT_EN.
- Defined:
  - Adds outputs audit_grants [7:0] and audit_denies [7:0].
  - Each increments once per grant or deny pulse and saturates at 255.
  - Both are cleared only by resetn.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good key with funds: balance=100, amount=30, req, then verify_done=1/correct=1 three cycles later → single grant pulse; new_balance=70; fail_count=0; grant on the second edge after the done-sampling edge.
- Insufficient funds: balance=10, amount=11, correct key → deny with code 11; fail_count unchanged; back to IDLE; new_balance holds its previous value.
- Three bad keys (MAX_FAILS=3): correct=0 on three consecutive transfers → deny code 01 each time; fail_count 1, 2, 3; locked=1 for 64 cycles. A req during lockout gives no pulse. After lockout, locked=0, fail_count=0, and a good key is granted.
- Timeout: req, verify_done never asserted → deny code 10 after exactly 16 WAIT_VERIFY cycles; fail_count+1. A second case with verify_done=1/correct=1 on cycle 16 gives a grant, not a timeout.
- Reset mid-operation: assert resetn=0 while in WAIT_VERIFY with fail_count=2 → all outputs zero immediately (asynchronous). After release the block is IDLE and a fresh transfer behaves normally.
- AUTH_AUDIT_EN defined: 2 grants and 1 deny → audit_grants=2, audit_denies=1. After 300 forced denies, audit_denies=255.

Source files
------------

// File: rtl/transfer_authorizer.sv
// transfer_authorizer: waits for key verification, checks funds, pulses grant/deny with reason, locks out after repeated key failures.
// Latency: grant/deny outputs are registered one cycle behind the FSM state (grant rises 2 edges after the verify_done sampling edge).
// Backpressure: none; req is sampled only in IDLE and ignored while busy or LOCKED. Optional audit counters under `AUTH_AUDIT_EN.
module transfer_authorizer #(
    parameter int AMT_W       = 8,
    parameter int MAX_FAILS   = 3,
    parameter int TIMEOUT     = 16,
    parameter int LOCK_CYCLES = 64
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic [AMT_W-1:0] balance,
    input  logic             verify_done,
    input  logic             correct,
    output logic             busy,
    output logic             grant,
    output logic             deny,
    output logic [1:0]       deny_code,
    output logic [AMT_W-1:0] new_balance,
    output logic             locked,
    output logic [2:0]       fail_count
`ifdef AUTH_AUDIT_EN
    ,
    output logic [7:0]       audit_grants,
    output logic [7:0]       audit_denies
`endif
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_KEY   = 2'b01;
    localparam logic [1:0] CODE_TMO   = 2'b10;
    localparam logic [1:0] CODE_FUNDS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VERIFY, S_CHECK_FUNDS, S_GRANT, S_DENY, S_LOCKED
    } state_t;

    state_t             r_state, w_next;
    logic [AMT_W-1:0]   r_amt, r_bal;
    logic [TW-1:0]      r_tmr;
    logic [LW-1:0]      r_lock_tmr;
    logic [1:0]         r_code, w_code_nxt;
    logic [2:0]         r_fail;
    logic               w_fail_inc;
    logic               w_lock_done;
    logic               r_busy, r_grant, r_deny, r_locked;
    logic [1:0]         r_deny_code;
    logic [AMT_W-1:0]   r_new_bal;

    assign w_lock_done = (r_lock_tmr == LW'(LOCK_CYCLES - 1));

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode; also flags key failures and picks the deny reason
    always_comb begin
        w_next     = r_state;
        w_fail_inc = 1'b0;
        w_code_nxt = r_code;
        case (r_state)
            S_IDLE: begin
                if (req) w_next = S_WAIT_VERIFY;
            end
            S_WAIT_VERIFY: begin
                // verify_done takes priority over an expiring timer
                if (verify_done) begin
                    if (correct) begin
                        w_next = S_CHECK_FUNDS;
                    end else begin
                        w_next     = S_DENY;
                        w_fail_inc = 1'b1;
                        w_code_nxt = CODE_KEY;
                    end
                end else if (r_tmr == TW'(TIMEOUT - 1)) begin
                    w_next     = S_DENY;
                    w_fail_inc = 1'b1;
                    w_code_nxt = CODE_TMO;
                end
            end
            S_CHECK_FUNDS: begin
                if (r_amt <= r_bal) begin
                    w_next = S_GRANT;
                end else begin
                    w_next     = S_DENY;
                    w_code_nxt = CODE_FUNDS;
                end
            end
            S_GRANT: w_next = S_IDLE;
            S_DENY:  w_next = (r_fail >= 3'(MAX_FAILS)) ? S_LOCKED : S_IDLE;
            S_LOCKED: begin
                if (w_lock_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latches, timers and the consecutive-failure counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_amt      <= '0;
            r_bal      <= '0;
            r_tmr      <= '0;
            r_lock_tmr <= '0;
            r_code     <= CODE_NONE;
            r_fail     <= '0;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_amt <= amount;
                r_bal <= balance;
                r_tmr <= '0;
            end else if (r_state == S_WAIT_VERIFY) begin
                r_tmr <= r_tmr + 1'b1;
            end
            r_lock_tmr <= (r_state == S_LOCKED) ? r_lock_tmr + 1'b1 : '0;
            r_code     <= w_code_nxt;
            if (r_state == S_GRANT || (r_state == S_LOCKED && w_lock_done))
                r_fail <= '0;
            else if (w_fail_inc && r_fail != 3'd7)
                r_fail <= r_fail + 3'd1;
        end
    end

    // Registered Moore outputs, one cycle behind the state they decode
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy      <= 1'b0;
            r_grant     <= 1'b0;
            r_deny      <= 1'b0;
            r_deny_code <= CODE_NONE;
            r_locked    <= 1'b0;
            r_new_bal   <= '0;
        end else begin
            r_busy      <= (r_state != S_IDLE);
            r_grant     <= (r_state == S_GRANT);
            r_deny      <= (r_state == S_DENY);
            r_deny_code <= (r_state == S_DENY) ? r_code : CODE_NONE;
            r_locked    <= (r_state == S_LOCKED);
            if (r_state == S_GRANT) r_new_bal <= r_bal - r_amt;
        end
    end

    assign busy        = r_busy;
    assign grant       = r_grant;
    assign deny        = r_deny;
    assign deny_code   = r_deny_code;
    assign locked      = r_locked;
    assign new_balance = r_new_bal;
    assign fail_count  = r_fail;

`ifdef AUTH_AUDIT_EN
    logic [7:0] r_aud_g, r_aud_d;

    // Saturating grant/deny event counters, cleared only by reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_aud_g <= '0;
            r_aud_d <= '0;
        end else begin
            if (r_state == S_GRANT && r_aud_g != 8'hFF) r_aud_g <= r_aud_g + 8'd1;
            if (r_state == S_DENY  && r_aud_d != 8'hFF) r_aud_d <= r_aud_d + 8'd1;
        end
    end

    assign audit_grants = r_aud_g;
    assign audit_denies = r_aud_d;
`endif

endmodule

// File: tb/tb_transfer_authorizer.sv
// Directed bench for transfer_authorizer: funds, key failures, lockout, timeout, async reset.
// Inputs are driven 1ns after the rising edge, outputs are sampled at the same point.
// Audit counter checks are compiled in only when AUTH_AUDIT_EN is defined.
module tb_transfer_authorizer;

    logic       clock, resetn, req, verify_done, correct;
    logic [7:0] amount, balance, new_balance;
    logic       busy, grant, deny, locked;
    logic [1:0] deny_code;
    logic [2:0] fail_count;
`ifdef AUTH_AUDIT_EN
    logic [7:0] audit_grants, audit_denies;
`endif

    int checks = 0;
    int errors = 0;

    transfer_authorizer dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .amount      (amount),
        .balance     (balance),
        .verify_done (verify_done),
        .correct     (correct),
        .busy        (busy),
        .grant       (grant),
        .deny        (deny),
        .deny_code   (deny_code),
        .new_balance (new_balance),
        .locked      (locked),
        .fail_count  (fail_count)
`ifdef AUTH_AUDIT_EN
        ,
        .audit_grants(audit_grants),
        .audit_denies(audit_denies)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue a request, wait dly WAIT_VERIFY cycles, then present one verify strobe.
    // Returns just after the edge that sampled verify_done.
    task automatic xfer(input logic [7:0] a, input logic [7:0] b, input int dly, input logic c);
        req = 1'b1; amount = a; balance = b;
        step();
        req = 1'b0; amount = ~a; balance = 8'd0;
        repeat (dly) step();
        verify_done = 1'b1; correct = c;
        step();
        verify_done = 1'b0; correct = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   busy,        0);
        check({tag, "_grant"},  grant,       0);
        check({tag, "_deny"},   deny,        0);
        check({tag, "_code"},   deny_code,   0);
        check({tag, "_newbal"}, new_balance, 0);
        check({tag, "_locked"}, locked,      0);
        check({tag, "_fail"},   fail_count,  0);
    endtask

    initial begin
        int n_locked;
        int n_pulse;
        req = 0; amount = 0; balance = 0; verify_done = 0; correct = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1 check_all_zero("reset");
        step(); step();
        resetn = 1'b1;
        step();

        // amount == balance boundary: grants, new_balance 0
        xfer(8'd40, 8'd40, 0, 1'b1);
        step(); step();
        check("eq_grant", grant, 1);
        check("eq_newbal", new_balance, 0);

        // good key with funds, done three cycles after request; inputs scrambled after accept
        xfer(8'd30, 8'd100, 2, 1'b1);
        check("good_busy", busy, 1);
        check("good_grant_d0", grant, 0);
        step();
        check("good_grant_d1", grant, 0);
        step();
        check("good_grant_d2", grant, 1);
        check("good_newbal", new_balance, 70);
        check("good_fail", fail_count, 0);
        check("good_deny", deny, 0);
        step();
        check("good_grant_end", grant, 0);
        check("good_idle", busy, 0);

        // insufficient funds: 11 > 10
        xfer(8'd11, 8'd10, 0, 1'b1);
        step();
        check("funds_deny_d1", deny, 0);
        step();
        check("funds_deny", deny, 1);
        check("funds_code", deny_code, 3);
        check("funds_fail", fail_count, 0);
        check("funds_newbal_held", new_balance, 70);
        step();
        check("funds_deny_end", deny, 0);
        check("funds_code_end", deny_code, 0);

        // three bad keys leading to lockout
        for (int k = 1; k <= 3; k++) begin
            xfer(8'd5, 8'd50, 0, 1'b0);
            check($sformatf("badkey%0d_fail", k), fail_count, k);
            step();
            check($sformatf("badkey%0d_deny", k), deny, 1);
            check($sformatf("badkey%0d_code", k), deny_code, 1);
        end
        check("lock_not_yet", locked, 0);
        n_locked = 0; n_pulse = 0;
        amount = 8'd1; balance = 8'd200;
        for (int i = 0; i < 70; i++) begin
            req = (i < 30);
            step();
            if (locked) n_locked++;
            if (grant || deny) n_pulse++;
            if (i == 10) begin
                check("lock_mid_locked", locked, 1);
                check("lock_mid_fail", fail_count, 3);
            end
        end
        req = 1'b0;
        check("lock_cycles", n_locked, 64);
        check("lock_no_pulse", n_pulse, 0);
        check("lock_released", locked, 0);
        check("lock_fail_clear", fail_count, 0);
        xfer(8'd20, 8'd50, 1, 1'b1);
        step(); step();
        check("postlock_grant", grant, 1);
        check("postlock_newbal", new_balance, 30);

        // timeout after exactly 16 WAIT_VERIFY cycles
        req = 1'b1; amount = 8'd1; balance = 8'd1;
        step();
        req = 1'b0;
        repeat (15) step();
        check("tmo_fail_c15", fail_count, 0);
        check("tmo_deny_c15", deny, 0);
        step();
        check("tmo_fail_c16", fail_count, 1);
        step();
        check("tmo_deny", deny, 1);
        check("tmo_code", deny_code, 2);

        // verify_done on the final timeout cycle wins
        xfer(8'd3, 8'd10, 15, 1'b1);
        check("lastcyc_fail", fail_count, 1);
        step();
        check("lastcyc_nodeny", deny, 0);
        step();
        check("lastcyc_grant", grant, 1);
        check("lastcyc_deny", deny, 0);
        check("lastcyc_newbal", new_balance, 7);
        check("lastcyc_fail_clear", fail_count, 0);

        // async reset while in WAIT_VERIFY with fail_count=2
        xfer(8'd5, 8'd50, 0, 1'b0); step();
        xfer(8'd5, 8'd50, 0, 1'b0); step();
        check("rst_pre_fail", fail_count, 2);
        req = 1'b1; amount = 8'd1; balance = 8'd9;
        step();
        req = 1'b0;
        step(); step();
        check("rst_pre_busy", busy, 1);
        resetn = 1'b0;
        #1 check_all_zero("midrst");
        #2 resetn = 1'b1;
        step();
        check("rst_post_busy", busy, 0);
        xfer(8'd0, 8'd5, 0, 1'b1);
        step(); step();
        check("rst_zero_grant", grant, 1);
        check("rst_zero_newbal", new_balance, 5);

`ifdef AUTH_AUDIT_EN
        step();
        resetn = 1'b0;
        #2 resetn = 1'b1;
        step();
        check("aud_reset_g", audit_grants, 0);
        xfer(8'd1, 8'd9, 0, 1'b1); step(); step();
        xfer(8'd1, 8'd9, 0, 1'b1); step(); step();
        xfer(8'd9, 8'd1, 0, 1'b1); step(); step();
        check("aud_grants", audit_grants, 2);
        check("aud_denies", audit_denies, 1);
        for (int i = 0; i < 299; i++) begin
            xfer(8'd2, 8'd1, 0, 1'b1); step(); step();
        end
        check("aud_denies_sat", audit_denies, 255);
        check("aud_grants_hold", audit_grants, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
